// File: rtl/ppi_pkg.sv
// ppi_pkg: shared encodings for the 8255A-style port-group controllers.
//   mode_e    : MODE_BASIC (mode 0 basic I/O), MODE_STROBED (mode 1 strobed I/O)
//   dir_e     : DIR_OUT (port drives pins), DIR_IN (port reads pins)
//   hs_select : picks the handshake status pin (IBF / OBF_n / 0) for a config
package ppi_pkg;

    typedef enum logic {
        MODE_BASIC   = 1'b0,
        MODE_STROBED = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_OUT = 1'b0,
        DIR_IN  = 1'b1
    } dir_e;

    // Synchroniser depth below two offers no metastability protection.
    localparam int MIN_SYNC_STAGES = 2;

    // Handshake status pin: IBF in strobed input, OBF_n in strobed output,
    // held low in basic I/O.
    function automatic logic hs_select(input mode_e mode, input dir_e dir,
                                       input logic ibf, input logic obf_n);
        if (mode == MODE_BASIC) begin
            return 1'b0;
        end
        return (dir == DIR_IN) ? ibf : obf_n;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous input plus
// registered one-cycle fall/rise pulses.
//   clk, rst_n : clock, synchronous active-low reset
//   din        : asynchronous input
//   level      : synchronised level, aligned with the fall/rise pulses
//   fall, rise : one-cycle pulses on a synchronised high->low / low->high edge
// An edge on din sampled at clock edge n produces a pulse that is visible
// to downstream logic at edge n + STAGES + 1.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
            fall  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
            fall  <= prev & ~chain[STAGES-1];
            rise  <= ~prev & chain[STAGES-1];
        end
    end

    // prev lags the chain output by one cycle, the same as the pulses.
    assign level = prev;

endmodule

// File: rtl/strobed_port_ctrl.sv
// strobed_port_ctrl: one 8255A-style port group in basic I/O (mode 0) or
// strobed handshake I/O (mode 1 input or output).
//   clk, rst_n      : clock, synchronous active-low reset
//   CfgWr/Mode/PortIn : control-word load (Mode 1 = strobed, PortIn 1 = input)
//   InteWr/InteVal  : INTE bit set/reset
//   Rd_n, Wr_n      : asynchronous chip-selected bus strobes
//   BusIn/BusOut    : CPU write data / read data
//   PinIn/PinOut/PinOe : port pins in, output latch, output enable
//   HsIn_n          : STB_n (strobed input) or ACK_n (strobed output)
//   HsOut           : IBF (strobed input) or OBF_n (strobed output), 0 in mode 0
//   Intr            : interrupt request, 0 in mode 0
//
// Strobe semantics: every asynchronous strobe (Rd_n, Wr_n, HsIn_n) is
// synchronised and reduced to one-cycle fall/rise pulses; state reacts only
// to those pulses, so a strobe must stay low and high for at least
// SYNC_STAGES + 1 cycles to be seen. PinIn runs through the same depth plus
// one register so data captured on an STB_n fall is the data present when
// STB_n fell. CfgWr overrides every event in the same cycle.
module strobed_port_ctrl
    import ppi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CfgWr,
    input  logic             Mode,
    input  logic             PortIn,
    input  logic             InteWr,
    input  logic             InteVal,
    input  logic             Rd_n,
    input  logic             Wr_n,
    input  logic [WIDTH-1:0] BusIn,
    output logic [WIDTH-1:0] BusOut,
    input  logic [WIDTH-1:0] PinIn,
    output logic [WIDTH-1:0] PinOut,
    output logic             PinOe,
    input  logic             HsIn_n,
    output logic             HsOut,
    output logic             Intr
);

    // ---------------- synchronisers ----------------
    logic rd_level, rd_fall, rd_rise;
    logic wr_level, wr_fall, wr_rise;
    logic hs_level, hs_fall, hs_rise;
    logic unused_levels;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rd (
        .clk(clk), .rst_n(rst_n), .din(Rd_n),
        .level(rd_level), .fall(rd_fall), .rise(rd_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_wr (
        .clk(clk), .rst_n(rst_n), .din(Wr_n),
        .level(wr_level), .fall(wr_fall), .rise(wr_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_hs (
        .clk(clk), .rst_n(rst_n), .din(HsIn_n),
        .level(hs_level), .fall(hs_fall), .rise(hs_rise)
    );

    // Bus strobes are only used as edges.
    assign unused_levels = rd_level ^ wr_level;

    logic [WIDTH-1:0] pin_sync [SYNC_STAGES];
    logic [WIDTH-1:0] pin_d;   // aligned with the registered strobe pulses

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pin_sync[i] <= '0;
            end
            pin_d <= '0;
        end else begin
            pin_sync[0] <= PinIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pin_sync[i] <= pin_sync[i-1];
            end
            pin_d <= pin_sync[SYNC_STAGES-1];
        end
    end

    // ---------------- port state ----------------
    mode_e            cfg_mode, cfg_mode_nx;
    dir_e             cfg_dir, cfg_dir_nx;
    logic [WIDTH-1:0] in_latch, in_latch_nx;
    logic [WIDTH-1:0] out_latch, out_latch_nx;
    logic [WIDTH-1:0] bus_hold, bus_hold_nx;   // BusIn captured on Wr_n fall
    logic             ibf, ibf_nx;
    logic             obf_n, obf_n_nx;
    logic             intr, intr_nx;
    logic             inte, inte_nx;
    logic             wrote, wrote_nx;         // a write happened since CfgWr
    logic [WIDTH-1:0] bus_out, bus_out_nx;
    logic             hs_out, hs_out_nx;
    logic             pin_oe, pin_oe_nx;

    always_comb begin
        cfg_mode_nx  = cfg_mode;
        cfg_dir_nx   = cfg_dir;
        in_latch_nx  = in_latch;
        out_latch_nx = out_latch;
        bus_hold_nx  = bus_hold;
        ibf_nx       = ibf;
        obf_n_nx     = obf_n;
        intr_nx      = intr;
        inte_nx      = inte;
        wrote_nx     = wrote;

        if (CfgWr) begin
            cfg_mode_nx  = mode_e'(Mode);
            cfg_dir_nx   = dir_e'(PortIn);
            in_latch_nx  = '0;
            out_latch_nx = '0;
            ibf_nx       = 1'b0;
            obf_n_nx     = 1'b1;
            intr_nx      = 1'b0;
            inte_nx      = 1'b0;
            wrote_nx     = 1'b0;
        end else begin
            if (wr_fall) begin
                bus_hold_nx = BusIn;
            end

            if (cfg_mode == MODE_BASIC) begin
                if (cfg_dir == DIR_OUT && wr_rise) begin
                    out_latch_nx = bus_hold;
                end
            end else if (cfg_dir == DIR_IN) begin
                // A new strobe on the same edge as the read completing keeps
                // the buffer full with the fresh data.
                if (hs_fall) begin
                    in_latch_nx = pin_d;
                    ibf_nx      = 1'b1;
                end else if (rd_rise) begin
                    ibf_nx = 1'b0;
                end
                if (hs_rise && ibf && inte) begin
                    intr_nx = 1'b1;
                end
                if (rd_fall) begin
                    intr_nx = 1'b0;
                end
            end else begin
                if (wr_fall) begin
                    intr_nx = 1'b0;
                end
                if (hs_fall) begin
                    obf_n_nx = 1'b1;
                end
                // Write after the ACK fall so a coincident write wins.
                if (wr_rise) begin
                    out_latch_nx = bus_hold;
                    obf_n_nx     = 1'b0;
                    wrote_nx     = 1'b1;
                end
                if (hs_rise && obf_n && inte) begin
                    intr_nx = 1'b1;
                end
            end

            if (InteWr) begin
                inte_nx = InteVal;
                if (!InteVal) begin
                    intr_nx = 1'b0;
                end else if (cfg_mode == MODE_STROBED) begin
                    if (cfg_dir == DIR_IN && ibf && hs_level) begin
                        intr_nx = 1'b1;
                    end
                    if (cfg_dir == DIR_OUT && obf_n && hs_level && wrote) begin
                        intr_nx = 1'b1;
                    end
                end
            end
        end

        // Output registers follow the next state so they change on the
        // same edge as the state itself.
        if (cfg_mode_nx == MODE_BASIC && cfg_dir_nx == DIR_IN) begin
            bus_out_nx = pin_d;
        end else if (cfg_dir_nx == DIR_IN) begin
            bus_out_nx = in_latch_nx;
        end else begin
            bus_out_nx = out_latch_nx;
        end
        hs_out_nx = hs_select(cfg_mode_nx, cfg_dir_nx, ibf_nx, obf_n_nx);
        pin_oe_nx = (cfg_dir_nx == DIR_OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_mode  <= MODE_BASIC;
            cfg_dir   <= DIR_IN;
            in_latch  <= '0;
            out_latch <= '0;
            bus_hold  <= '0;
            ibf       <= 1'b0;
            obf_n     <= 1'b1;
            intr      <= 1'b0;
            inte      <= 1'b0;
            wrote     <= 1'b0;
            bus_out   <= '0;
            hs_out    <= 1'b0;
            pin_oe    <= 1'b0;
        end else begin
            cfg_mode  <= cfg_mode_nx;
            cfg_dir   <= cfg_dir_nx;
            in_latch  <= in_latch_nx;
            out_latch <= out_latch_nx;
            bus_hold  <= bus_hold_nx;
            ibf       <= ibf_nx;
            obf_n     <= obf_n_nx;
            intr      <= intr_nx;
            inte      <= inte_nx;
            wrote     <= wrote_nx;
            bus_out   <= bus_out_nx;
            hs_out    <= hs_out_nx;
            pin_oe    <= pin_oe_nx;
        end
    end

    assign BusOut = bus_out;
    assign PinOut = out_latch;
    assign PinOe  = pin_oe;
    assign HsOut  = hs_out;
    assign Intr   = intr;

endmodule

// File: tb/tb_strobed_port_ctrl.sv
// Bench for strobed_port_ctrl: one 8-bit and one 16-bit instance share all
// control strobes; 16-bit data is the 8-bit value replicated twice.
// Expectations are queued at a falling clock edge and checked by a separate
// monitor 2 ns later, while DUT outputs are stable.
module tb_strobed_port_ctrl;

    localparam int S_BUS8   = 0;
    localparam int S_BUS16  = 1;
    localparam int S_PIN8   = 2;
    localparam int S_PIN16  = 3;
    localparam int S_OE8    = 4;
    localparam int S_OE16   = 5;
    localparam int S_HS8    = 6;
    localparam int S_HS16   = 7;
    localparam int S_INTR8  = 8;
    localparam int S_INTR16 = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_wr, mode, port_in, inte_wr, inte_val;
    logic        rd_n, wr_n, hs_in_n;
    logic [7:0]  bus_in8, pin_in8, bus_out8, pin_out8;
    logic [15:0] bus_in16, pin_in16, bus_out16, pin_out16;
    logic        pin_oe8, hs_out8, intr8;
    logic        pin_oe16, hs_out16, intr16;

    strobed_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n), .CfgWr(cfg_wr), .Mode(mode), .PortIn(port_in),
        .InteWr(inte_wr), .InteVal(inte_val), .Rd_n(rd_n), .Wr_n(wr_n),
        .BusIn(bus_in8), .BusOut(bus_out8), .PinIn(pin_in8), .PinOut(pin_out8),
        .PinOe(pin_oe8), .HsIn_n(hs_in_n), .HsOut(hs_out8), .Intr(intr8)
    );

    strobed_port_ctrl #(.WIDTH(16), .SYNC_STAGES(2)) u16 (
        .clk(clk), .rst_n(rst_n), .CfgWr(cfg_wr), .Mode(mode), .PortIn(port_in),
        .InteWr(inte_wr), .InteVal(inte_val), .Rd_n(rd_n), .Wr_n(wr_n),
        .BusIn(bus_in16), .BusOut(bus_out16), .PinIn(pin_in16), .PinOut(pin_out16),
        .PinOe(pin_oe16), .HsIn_n(hs_in_n), .HsOut(hs_out16), .Intr(intr16)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    chk_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] actual(input int sel);
        case (sel)
            S_BUS8:   return {8'h00, bus_out8};
            S_BUS16:  return bus_out16;
            S_PIN8:   return {8'h00, pin_out8};
            S_PIN16:  return pin_out16;
            S_OE8:    return {15'd0, pin_oe8};
            S_OE16:   return {15'd0, pin_oe16};
            S_HS8:    return {15'd0, hs_out8};
            S_HS16:   return {15'd0, hs_out16};
            S_INTR8:  return {15'd0, intr8};
            default:  return {15'd0, intr16};
        endcase
    endfunction

    chk_t        cur;
    logic [15:0] act;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                act = actual(cur.sel);
                checks++;
                if (act !== cur.exp) begin
                    errors++;
                    $display("FAIL %s sel=%0d got=%h expected=%h", cur.name, cur.sel, act, cur.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string name, input int sel, input logic [15:0] v);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = v;
        exp_q.push_back(c);
    endtask

    task automatic chk_ctl(input string name, input logic oe, input logic hs, input logic ir);
        push({name, ".oe"}, S_OE8, {15'd0, oe});
        push({name, ".oe"}, S_OE16, {15'd0, oe});
        push({name, ".hs"}, S_HS8, {15'd0, hs});
        push({name, ".hs"}, S_HS16, {15'd0, hs});
        push({name, ".intr"}, S_INTR8, {15'd0, ir});
        push({name, ".intr"}, S_INTR16, {15'd0, ir});
    endtask

    task automatic chk_bus(input string name, input logic [7:0] v);
        push({name, ".bus"}, S_BUS8, {8'h00, v});
        push({name, ".bus"}, S_BUS16, {v, v});
    endtask

    task automatic chk_pin(input string name, input logic [7:0] v);
        push({name, ".pin"}, S_PIN8, {8'h00, v});
        push({name, ".pin"}, S_PIN16, {v, v});
    endtask

    task automatic set_pins(input logic [7:0] v);
        pin_in8  = v;
        pin_in16 = {v, v};
    endtask

    task automatic set_bus(input logic [7:0] v);
        bus_in8  = v;
        bus_in16 = {v, v};
    endtask

    task automatic cfg(input logic m, input logic d);
        cfg_wr  = 1'b1;
        mode    = m;
        port_in = d;
        cyc(1);
        cfg_wr  = 1'b0;
    endtask

    task automatic inte_set(input logic v);
        inte_wr  = 1'b1;
        inte_val = v;
        cyc(1);
        inte_wr  = 1'b0;
    endtask

    // Strobe low 4 cycles then high 4 cycles.
    task automatic pulse_hs();
        hs_in_n = 1'b0;
        cyc(4);
        hs_in_n = 1'b1;
        cyc(4);
    endtask

    task automatic pulse_wr(input logic [7:0] v);
        set_bus(v);
        wr_n = 1'b0;
        cyc(4);
        wr_n = 1'b1;
        cyc(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; cfg_wr = 1'b0; mode = 1'b0; port_in = 1'b0;
        inte_wr = 1'b0; inte_val = 1'b0; rd_n = 1'b1; wr_n = 1'b1; hs_in_n = 1'b1;
        set_pins(8'h00);
        set_bus(8'h00);

        cyc(2);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk_bus("reset", 8'h00);
        chk_pin("reset", 8'h00);
        rst_n = 1'b1;
        cyc(1);

        // ---- mode 1 output ----
        cfg(1'b1, 1'b0);
        chk_ctl("cfg_m1out", 1'b1, 1'b1, 1'b0);
        chk_pin("cfg_m1out", 8'h00);
        inte_set(1'b1);
        chk_ctl("inte_no_write", 1'b1, 1'b1, 1'b0);

        set_bus(8'h3C);
        wr_n = 1'b0;
        cyc(4);
        wr_n = 1'b1;
        cyc(3);
        chk_ctl("wr_rise_pre", 1'b1, 1'b1, 1'b0);
        chk_pin("wr_rise_pre", 8'h00);
        cyc(1);
        chk_ctl("wr_rise", 1'b1, 1'b0, 1'b0);
        chk_pin("wr_rise", 8'h3C);
        chk_bus("wr_rise", 8'h3C);

        hs_in_n = 1'b0;
        cyc(4);
        chk_ctl("ack_fall", 1'b1, 1'b1, 1'b0);
        hs_in_n = 1'b1;
        cyc(3);
        chk_ctl("ack_rise_pre", 1'b1, 1'b1, 1'b0);
        cyc(1);
        chk_ctl("ack_rise", 1'b1, 1'b1, 1'b1);

        set_bus(8'hC3);
        wr_n = 1'b0;
        cyc(4);
        chk_ctl("wr_fall_clr", 1'b1, 1'b1, 1'b0);
        wr_n = 1'b1;
        cyc(4);
        chk_ctl("wr2", 1'b1, 1'b0, 1'b0);
        chk_pin("wr2", 8'hC3);

        // Write rise and ACK fall land on the same edge.
        set_bus(8'h5A);
        wr_n = 1'b0;
        cyc(4);
        wr_n = 1'b1;
        hs_in_n = 1'b0;
        cyc(4);
        chk_ctl("wr_ack_same", 1'b1, 1'b0, 1'b0);
        chk_pin("wr_ack_same", 8'h5A);
        hs_in_n = 1'b1;
        cyc(4);
        chk_ctl("ack_rise_full", 1'b1, 1'b0, 1'b0);

        pulse_hs();
        chk_ctl("ack2", 1'b1, 1'b1, 1'b1);
        inte_set(1'b0);
        chk_ctl("inte_clr_out", 1'b1, 1'b1, 1'b0);

        pulse_wr(8'h11);
        chk_ctl("wr3", 1'b1, 1'b0, 1'b0);
        chk_pin("wr3", 8'h11);
        pulse_hs();
        chk_ctl("ack_no_inte", 1'b1, 1'b1, 1'b0);
        inte_set(1'b1);
        chk_ctl("inte_set_out", 1'b1, 1'b1, 1'b1);

        // ---- mode 1 input ----
        cfg(1'b1, 1'b1);
        chk_ctl("cfg_m1in", 1'b0, 1'b0, 1'b0);
        chk_bus("cfg_m1in", 8'h00);
        chk_pin("cfg_m1in", 8'h00);
        inte_set(1'b1);
        chk_ctl("inte_set_empty", 1'b0, 1'b0, 1'b0);

        set_pins(8'hA5);
        hs_in_n = 1'b0;
        cyc(3);
        chk_ctl("stb_fall_pre", 1'b0, 1'b0, 1'b0);
        cyc(1);
        chk_ctl("stb_fall", 1'b0, 1'b1, 1'b0);
        chk_bus("stb_fall", 8'hA5);
        hs_in_n = 1'b1;
        set_pins(8'h77);
        cyc(3);
        chk_ctl("stb_rise_pre", 1'b0, 1'b1, 1'b0);
        cyc(1);
        chk_ctl("stb_rise", 1'b0, 1'b1, 1'b1);
        chk_bus("stb_rise", 8'hA5);

        rd_n = 1'b0;
        cyc(4);
        chk_ctl("rd_fall", 1'b0, 1'b1, 1'b0);
        chk_bus("rd_fall", 8'hA5);
        rd_n = 1'b1;
        cyc(4);
        chk_ctl("rd_rise", 1'b0, 1'b0, 1'b0);

        // STB fall and read completion land on the same edge.
        set_pins(8'h3C);
        pulse_hs();
        chk_ctl("stb2", 1'b0, 1'b1, 1'b1);
        chk_bus("stb2", 8'h3C);
        rd_n = 1'b0;
        cyc(4);
        set_pins(8'hC6);
        rd_n = 1'b1;
        hs_in_n = 1'b0;
        cyc(4);
        chk_ctl("stb_rd_same", 1'b0, 1'b1, 1'b0);
        chk_bus("stb_rd_same", 8'hC6);
        hs_in_n = 1'b1;
        cyc(4);
        chk_ctl("stb_rd_same_rise", 1'b0, 1'b1, 1'b1);

        // Reconfiguration mid-handshake.
        cfg(1'b1, 1'b1);
        chk_ctl("reconfig", 1'b0, 1'b0, 1'b0);
        chk_bus("reconfig", 8'h00);
        set_pins(8'h99);
        pulse_hs();
        chk_ctl("inte_cleared", 1'b0, 1'b1, 1'b0);
        chk_bus("inte_cleared", 8'h99);

        // ---- mode 0 output ----
        cfg(1'b0, 1'b0);
        chk_ctl("cfg_m0out", 1'b1, 1'b0, 1'b0);
        chk_pin("cfg_m0out", 8'h00);
        chk_bus("cfg_m0out", 8'h00);
        set_bus(8'hFF);
        wr_n = 1'b0;
        cyc(4);
        wr_n = 1'b1;
        cyc(3);
        chk_pin("m0_wr_pre", 8'h00);
        cyc(1);
        chk_pin("m0_wr", 8'hFF);
        chk_bus("m0_wr", 8'hFF);
        chk_ctl("m0_wr", 1'b1, 1'b0, 1'b0);
        inte_set(1'b1);
        pulse_hs();
        chk_ctl("m0_hs_ignored", 1'b1, 1'b0, 1'b0);

        // ---- mode 0 input ----
        cfg(1'b0, 1'b1);
        chk_ctl("cfg_m0in", 1'b0, 1'b0, 1'b0);
        chk_pin("cfg_m0in", 8'h00);
        chk_bus("cfg_m0in", 8'h99);
        set_pins(8'h12);
        cyc(3);
        chk_bus("m0_in_pre", 8'h99);
        cyc(1);
        chk_bus("m0_in", 8'h12);
        chk_ctl("m0_in", 1'b0, 1'b0, 1'b0);

        cyc(1);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
